// File: rtl/pipe_reg_m_wb_elastic_pkg.sv
// Shared widths and payload layout for the MEM->WB elastic pipeline register.
// Payload packing, MSB first: {reg_write, mem_to_reg, alu_result, data_load, dst}.
package pipe_reg_m_wb_elastic_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

  function automatic int wb_payload_w(input int data_w, input int reg_addr_w);
    return 2 + 2 * data_w + reg_addr_w;
  endfunction

  function automatic int alu_lsb(input int data_w, input int reg_addr_w);
    return reg_addr_w + data_w;
  endfunction

  function automatic int load_lsb(input int reg_addr_w);
    return reg_addr_w;
  endfunction

endpackage

// File: rtl/pipe_reg_m_wb_elastic_pipe_slot.sv
// One storage entry of the elastic register: a valid flag plus a W-bit payload.
// clear has priority over load; the payload holds its value when cleared.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // NOTE: the payload is reset as well as valid, so every output reads 0 while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_reg_m_wb_elastic.sv
// MEM->WB pipeline register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush, r0 write suppression and a forwarding tap for the hazard unit.
module pipe_reg_m_wb_elastic
  import pipe_reg_m_wb_elastic_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int ZERO_GUARD = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_reg_write,
  input  logic                  in_mem_to_reg,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_data_load,
  input  logic [REG_ADDR_W-1:0] in_dst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_reg_write,
  output logic                  out_mem_to_reg,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [DATA_W-1:0]     out_data_load,
  output logic [REG_ADDR_W-1:0] out_dst,
  output logic [DATA_W-1:0]     out_wb_data,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_dst,
  output logic [DATA_W-1:0]     fwd_data
);

  localparam int PW       = wb_payload_w(DATA_W, REG_ADDR_W);
  localparam int RW_BIT   = PW - 1;
  localparam int M2R_BIT  = PW - 2;
  localparam int ALU_LSB  = alu_lsb(DATA_W, REG_ADDR_W);
  localparam int LOAD_LSB = load_lsb(REG_ADDR_W);

  logic          h_valid, s_valid;
  logic [PW-1:0] h_q, s_q, h_d, in_payload;
  logic          h_load, h_clear, s_load, s_clear;
  logic          accept, pop, guarded_rw;

  // Guard is applied at capture so a stored r0 beat can never assert a write.
  assign guarded_rw = (ZERO_GUARD != 0) ? (in_reg_write & (in_dst != '0)) : in_reg_write;
  assign in_payload = {guarded_rw, in_mem_to_reg, in_alu_result, in_data_load, in_dst};

  // Ready depends only on registered state, never on out_ready.
  assign in_ready = rst & ~s_valid;
  assign accept   = in_valid & in_ready;
  assign pop      = h_valid & out_ready;

  // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    h_load  = 1'b0;
    h_clear = 1'b0;
    s_load  = 1'b0;
    s_clear = 1'b0;
    h_d     = in_payload;
    if (flush) begin
      h_clear = 1'b1;
      s_clear = 1'b1;
    end else if (!h_valid || (pop && !s_valid)) begin
      h_load  = accept;
      h_clear = ~accept;
    end else if (pop) begin
      h_load  = 1'b1;
      h_d     = s_q;
      s_clear = 1'b1;
    end else begin
      s_load  = accept;
    end
  end

  pipe_slot #(.W(PW)) u_head (
    .clk(clk), .rst(rst), .load(h_load), .clear(h_clear),
    .d(h_d), .valid(h_valid), .q(h_q)
  );

  pipe_slot #(.W(PW)) u_skid (
    .clk(clk), .rst(rst), .load(s_load), .clear(s_clear),
    .d(in_payload), .valid(s_valid), .q(s_q)
  );

  assign out_valid      = h_valid;
  assign out_reg_write  = h_valid & h_q[RW_BIT];
  assign out_mem_to_reg = h_q[M2R_BIT];
  assign out_alu_result = h_q[ALU_LSB +: DATA_W];
  assign out_data_load  = h_q[LOAD_LSB +: DATA_W];
  assign out_dst        = h_q[REG_ADDR_W-1:0];
  assign out_wb_data    = out_mem_to_reg ? out_data_load : out_alu_result;

  assign fwd_valid = out_valid & out_reg_write;
  assign fwd_dst   = out_dst;
  assign fwd_data  = out_wb_data;

endmodule

// File: tb/tb_pipe_reg_m_wb_elastic.sv
// Directed bench for pipe_reg_m_wb_elastic: reset, streaming, backpressure,
// writeback mux, r0 guard, flush and reset mid-transfer.
module tb_pipe_reg_m_wb_elastic;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic        in_reg_write, in_mem_to_reg;
  logic [31:0] in_alu_result, in_data_load;
  logic [4:0]  in_dst;
  logic        out_valid, out_ready, out_reg_write, out_mem_to_reg;
  logic [31:0] out_alu_result, out_data_load, out_wb_data, fwd_data;
  logic [4:0]  out_dst, fwd_dst;
  logic        fwd_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_reg_m_wb_elastic #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_GUARD(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_alu_result(in_alu_result), .in_data_load(in_data_load), .in_dst(in_dst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
    .out_alu_result(out_alu_result), .out_data_load(out_data_load), .out_dst(out_dst),
    .out_wb_data(out_wb_data),
    .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [4:0] dst);
    in_valid      = v;
    in_reg_write  = rw;
    in_mem_to_reg = m2r;
    in_alu_result = alu;
    in_data_load  = ld;
    in_dst        = dst;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'hAAAA_5555, 32'h1234_5678, 5'd9);
    step(); step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if ({out_reg_write, out_mem_to_reg, out_alu_result, out_data_load, out_dst, out_wb_data,
                  fwd_valid, fwd_dst, fwd_data} !== '0) begin
      bad++; $display("FAIL reset_outputs_zero got wb=%h dst=%h fwd=%b", out_wb_data, out_dst, fwd_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rst = 1'b1;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_streaming();
    logic [31:0] alu_vals [4] = '{32'h10, 32'h11, 32'h12, 32'h13};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, alu_vals[i], 32'hFFFF_0000, 5'(i + 1));
      step();
      total++; if (out_valid !== 1'b1 || out_dst !== 5'(i + 1)) begin
        bad++; $display("FAIL stream_dst[%0d] got v=%b dst=%0d want v=1 dst=%0d", i, out_valid, out_dst, i + 1);
      end
      total++; if (out_wb_data !== alu_vals[i]) begin
        bad++; $display("FAIL stream_wb[%0d] got=%h want=%h", i, out_wb_data, alu_vals[i]);
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b want=1", i, in_ready); end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 5'd5);
    step();
    total++; if (out_valid !== 1'b1 || out_dst !== 5'd5 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_first got v=%b dst=%0d rdy=%b want 1/5/1", out_valid, out_dst, in_ready);
    end
    drive(1'b1, 1'b1, 1'b0, 32'h66, 32'h0, 5'd6);
    step();
    total++; if (in_ready !== 1'b0 || out_dst !== 5'd5) begin
      bad++; $display("FAIL bp_full got rdy=%b dst=%0d want 0/5", in_ready, out_dst);
    end
    drive(1'b1, 1'b1, 1'b0, 32'h77, 32'h0, 5'd7);
    step();
    total++; if (out_dst !== 5'd5 || out_wb_data !== 32'h55 || in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_hold got dst=%0d wb=%h rdy=%b want 5/55/0", out_dst, out_wb_data, in_ready);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_dst !== 5'd6 || out_wb_data !== 32'h66 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_second got v=%b dst=%0d wb=%h rdy=%b want 1/6/66/1",
                      out_valid, out_dst, out_wb_data, in_ready);
    end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got v=%b dst=%0d want v=0", out_valid, out_dst); end
  endtask

  task automatic test_mux();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'h1, 32'hDEAD_BEEF, 5'd3);
    step();
    total++; if (out_wb_data !== 32'hDEAD_BEEF || fwd_data !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL mux_load got wb=%h fwd=%h want deadbeef", out_wb_data, fwd_data);
    end
    total++; if (fwd_valid !== 1'b1 || fwd_dst !== 5'd3 || out_reg_write !== 1'b1) begin
      bad++; $display("FAIL mux_fwd got fv=%b fd=%0d rw=%b want 1/3/1", fwd_valid, fwd_dst, out_reg_write);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
  endtask

  task automatic test_zero_guard();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h99, 32'h0, 5'd0);
    step();
    total++; if (out_valid !== 1'b1 || out_reg_write !== 1'b0 || fwd_valid !== 1'b0) begin
      bad++; $display("FAIL zero_guard got v=%b rw=%b fv=%b want 1/0/0", out_valid, out_reg_write, fwd_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h88, 32'h0, 5'd8);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h99, 32'h0, 5'd9);
    step();
    total++; if (in_ready !== 1'b0 || out_dst !== 5'd8) begin
      bad++; $display("FAIL flush_prefill got rdy=%b dst=%0d want 0/8", in_ready, out_dst);
    end
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'hAA, 32'h0, 5'd10);
    step();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_reg_write !== 1'b0 || fwd_valid !== 1'b0) begin
      bad++; $display("FAIL flush_full got v=%b rdy=%b rw=%b fv=%b want 0/1/0/0",
                      out_valid, in_ready, out_reg_write, fwd_valid);
    end
    drive(1'b1, 1'b1, 1'b0, 32'hBB, 32'h0, 5'd11);
    step();
    total++; if (out_valid !== 1'b0 || fwd_valid !== 1'b0) begin
      bad++; $display("FAIL flush_accept got v=%b fv=%b want 0/0", out_valid, fwd_valid);
    end
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_reappear got v=%b dst=%0d want v=0", out_valid, out_dst); end
    drive(1'b1, 1'b1, 1'b0, 32'hCC, 32'h0, 5'd12);
    step();
    total++; if (out_valid !== 1'b1 || out_dst !== 5'd12 || out_wb_data !== 32'hCC) begin
      bad++; $display("FAIL flush_recover got v=%b dst=%0d wb=%h want 1/12/cc", out_valid, out_dst, out_wb_data);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
  endtask

  task automatic test_reset_mid_transfer();
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 5'd4);
    step();
    #1 rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_wb_data !== 32'h0) begin
      bad++; $display("FAIL midreset_async got v=%b rdy=%b wb=%h want 0/0/0", out_valid, in_ready, out_wb_data);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL midreset_release got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_mux();
    test_zero_guard();
    test_flush();
    test_reset_mid_transfer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
